// File: rtl/im_loader_if.sv
// Instruction-word stream into the IM loader: valid/ready handshake, 32-bit words.
interface im_loader_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/im_loader.sv
// Boot-time instruction-memory writer; holds the CPU in reset until the load completes.
// Optional trailing-checksum word verification enabled by IM_LOADER_CHECKSUM_EN.
module im_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
    parameter int          DEPTH     = 4096,
    parameter int          CNT_W     = 13
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    im_loader_if.slave       in_if,
    output logic             im_we,
    output logic [31:0]      im_addr,
    output logic [31:0]      im_wdata,
    output logic             cpu_reset,
    output logic             busy,
    output logic             done,
    output logic             err
);

`ifdef IM_LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, LOAD, DONE, CHECK} state_t;
    logic [31:0] sum;
`else
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
`endif

    state_t           state, state_next;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] cnt_inc;
    logic             len_ok;
    logic             accept;
    logic             last_word;

    assign len_ok    = (len != '0) && (len <= CNT_W'(DEPTH));
    assign cnt_inc   = counter + CNT_W'(1);
    assign last_word = (cnt_inc == len_q);

`ifdef IM_LOADER_CHECKSUM_EN
    assign in_if.in_ready = ((state == LOAD) && (counter < len_q)) || (state == CHECK);
`else
    assign in_if.in_ready = (state == LOAD) && (counter < len_q);
`endif
    assign accept = in_if.in_valid && in_if.in_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start && len_ok) state_next = LOAD;
            LOAD: if (accept && last_word) begin
`ifdef IM_LOADER_CHECKSUM_EN
                state_next = CHECK;
`else
                state_next = DONE;
`endif
            end
`ifdef IM_LOADER_CHECKSUM_EN
            CHECK: if (accept) state_next = (in_if.in_data == sum) ? DONE : IDLE;
`endif
            DONE: if (start) state_next = len_ok ? LOAD : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_q     <= '0;
            counter   <= '0;
            im_we     <= 1'b0;
            im_addr   <= BASE_ADDR;
            im_wdata  <= '0;
            cpu_reset <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
            sum       <= '0;
`endif
        end else begin
            im_we <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        cpu_reset <= 1'b1;
                        done      <= 1'b0;
                        if (len_ok) begin
                            len_q   <= len;
                            counter <= '0;
                            err     <= 1'b0;
                            busy    <= 1'b1;
`ifdef IM_LOADER_CHECKSUM_EN
                            sum     <= '0;
`endif
                        end else begin
                            err <= 1'b1;
                        end
                    end else if (state == DONE) begin
                        // Release lands one cycle after the final write pulse.
                        cpu_reset <= 1'b0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        im_we    <= 1'b1;
                        im_addr  <= BASE_ADDR + {{(30-CNT_W){1'b0}}, counter, 2'b00};
                        im_wdata <= in_if.in_data;
                        counter  <= cnt_inc;
`ifdef IM_LOADER_CHECKSUM_EN
                        sum      <= sum + in_if.in_data;
`else
                        if (last_word) begin
                            busy <= 1'b0;
                            done <= 1'b1;
                        end
`endif
                    end
                end
`ifdef IM_LOADER_CHECKSUM_EN
                CHECK: begin
                    if (accept) begin
                        busy <= 1'b0;
                        if (in_if.in_data == sum) done <= 1'b1;
                        else                      err  <= 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: doc/im_loader.md
Name: im_loader

Overview:
- Boot-time writer for the instruction memory. It drives the IM write port that the fetch unit reads.
- Accepts a stream of instruction words over a valid/ready handshake and stores them as consecutive words starting at the reset PC, 0x0000_3000.
- Holds the CPU in reset via cpu_reset until the load completes, then releases it so fetch starts at the first loaded instruction.

Parameters:
- BASE_ADDR, 32'h0000_3000, byte address written by the first word; equals the CPU reset PC.
- DEPTH, 4096, IM capacity in 32-bit words.
- CNT_W, 13, width of the word counter and len; must hold DEPTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a load.
- len  input  CNT_W  number of words to load; sampled when start is accepted.
- in_valid  input  1  in_data holds a valid word.
- in_data  input  32  instruction word.
- in_ready  output  1  loader accepts a word this cycle.
- im_we  output  1  IM write enable, one cycle per word.
- im_addr  output  32  IM byte address, word aligned.
- im_wdata  output  32  IM write data.
- cpu_reset  output  1  active-high hold for the CPU; 1 = CPU held in reset.
- busy  output  1  load in progress.
- done  output  1  last load completed successfully.
- err  output  1  last request rejected, or checksum failed.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; cpu_reset=1; im_we=0; im_addr=BASE_ADDR; im_wdata=0; busy=0; done=0; err=0; counter=0.
- States: IDLE, LOAD, DONE. With IM_LOADER_CHECKSUM_EN defined, a CHECK state is added.
- IDLE, start=1:
  - len==0 or len>DEPTH: err<=1, stay IDLE, cpu_reset stays 1.
  - Otherwise: latch len, counter<=0, err<=0, done<=0, busy<=1, go to LOAD.
- LOAD:
  - in_ready = (state==LOAD) && (counter<len_q). in_ready is combinational from registered state only and never depends on in_valid.
  - Handshake: a word transfers on a clock edge where in_valid && in_ready. A producer may hold in_valid high across cycles; each accepting edge consumes one word.
  - Write latency is one cycle. On the edge after an accept: im_we=1, im_addr=BASE_ADDR+4*counter_old, im_wdata=word. im_we=0 on cycles with no accept the previous edge.
  - Back-to-back accepts produce back-to-back write pulses at consecutive addresses.
  - counter increments per accept. When the accepted word is number len_q, go to DONE on the same edge; in_ready is 0 from that edge on.
  - start is ignored in LOAD.
- DONE:
  - The final im_we pulse occurs in the first DONE cycle.
  - cpu_reset<=0 on the edge ending that cycle, so the CPU leaves reset one cycle after the last write.
  - busy=0, done=1, both held.
- DONE, start=1: same checks as IDLE.
  - Valid len: cpu_reset<=1 on the same edge, done<=0, go to LOAD.
  - Invalid len: err<=1, cpu_reset<=1, done<=0, go to IDLE.
- Address arithmetic is 32-bit unsigned. The maximum address is BASE_ADDR+4*(DEPTH-1); no wrap occurs because len<=DEPTH.
- Reset mid-load: immediate return to IDLE with the reset values above. Partially written IM contents are left as is. cpu_reset stays 1 until a later load completes.
- in_valid while in_ready=0: ignored, no state change.

Optional Feature:
- Macro: IM_LOADER_CHECKSUM_EN.
- Defined:
  - A 32-bit running sum (mod 2^32) of accepted words is cleared on start.
  - After word len_q, go to CHECK instead of DONE. in_ready=1 for exactly one more word, the checksum; it is not written to IM.
  - Match: DONE (cpu_reset released one cycle later).
  - Mismatch: err<=1, busy<=0, go to IDLE, cpu_reset stays 1.
- Not defined: no CHECK state, no sum register, behaviour exactly as above.

Test Plan:
- Reset sequence: hold reset=0 for 3 cycles, then release -> cpu_reset=1, im_we=0, busy=0, done=0, err=0, im_addr=0x3000.
- Streaming load: start with len=3; words 0x3C010001, 0x34210002, 0x00000000 with in_valid held high -> im_we pulses at 0x3000, 0x3004, 0x3008 with matching data on consecutive cycles; cpu_reset falls exactly one cycle after the third pulse; done=1.
- Producer stalls: len=2 with in_valid toggling 1,0,0,1 -> writes only on the cycles after accepts; addresses 0x3000 then 0x3004; no extra pulses.
- Rejected requests: start with len=0, then with len=4097 -> err=1, state IDLE, no im_we, cpu_reset=1.
- Reload and abort: after DONE, start len=2 -> cpu_reset returns to 1 the next cycle. Assert reset=0 after one accepted word -> all outputs at reset values immediately, without waiting for a clock edge.
- Checksum (macro defined): len=2, words 5 and 7, checksum 12 -> done=1, cpu_reset released. Repeat with checksum 13 -> err=1, cpu_reset=1, no third im_we.
